// File: rtl/math_pkg.sv
// Shared math definitions: log-domain output format, iterative log2 FSM
// states and the parameter consistency check used at elaboration.
package math_pkg;

  // u6.6 log-domain format, common to the log2 and antilog blocks.
  localparam int LOG_INT_BITS  = 6;
  localparam int LOG_FRAC_BITS = 6;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    SQR,
    DONE
  } log2_state_e;

  // The integer part of the result (leading-one position minus fractional
  // input bits) must fit in the output integer field.
  function automatic bit log2_widths_ok(input int din_width,
                                        input int din_frac,
                                        input int int_bits);
    return (din_width - din_frac) <= (1 << int_bits);
  endfunction

endpackage

// File: rtl/math_lead_one.sv
// Combinational leading-one detector: position of the most significant set
// bit of vec, plus a flag saying whether any bit was set at all.
module math_lead_one #(
  parameter int WIDTH = 24,
  parameter int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [POS_W-1:0] pos,
  output logic             found
);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise an unassigned path infers a latch.
    pos   = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        pos   = POS_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/math_log2_iter.sv
// Iterative base-2 logarithm. Normalises the input to 1.f with a leading-one
// detect, then squares the mantissa FRAC_BITS times, producing one
// fractional result bit per cycle. Output is u(INT_BITS).(FRAC_BITS).
// rst_n is expected to be synchronised for deassertion outside this block.
module math_log2_iter
  import math_pkg::*;
#(
  parameter int DIN_WIDTH  = 24,
  parameter int DIN_FRAC   = 8,
  parameter int MANT_WIDTH = 16,
  parameter int INT_BITS   = LOG_INT_BITS,
  parameter int FRAC_BITS  = LOG_FRAC_BITS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIN_WIDTH-1:0]          DIN,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic [INT_BITS+FRAC_BITS-1:0] DOUT,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          underflow,
  output logic                          zero
);

  localparam int POS_W = (DIN_WIDTH > 1) ? $clog2(DIN_WIDTH) : 1;
  localparam int CNT_W = $clog2(FRAC_BITS + 1);
  localparam int OUT_W = INT_BITS + FRAC_BITS;
  localparam int EXT_W = DIN_WIDTH + MANT_WIDTH;
  localparam int SQ_W  = 2 * (MANT_WIDTH + 1);

  // Refuse to elaborate when the integer part could overflow its field.
  if (!log2_widths_ok(DIN_WIDTH, DIN_FRAC, INT_BITS)) begin : g_width_check
    $error("math_log2_iter: DIN_WIDTH-DIN_FRAC exceeds 2^INT_BITS");
  end

  log2_state_e            state_q, state_d;
  logic [DIN_WIDTH-1:0]   din_q;
  logic [MANT_WIDTH:0]    mant_q;      // 1.MANT_WIDTH, leading one explicit
  logic [INT_BITS-1:0]    exp_q;
  logic [FRAC_BITS-1:0]   frac_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [OUT_W-1:0]       dout_q;
  logic                   underflow_q;
  logic                   zero_q;

  logic                   accept;
  logic                   last_iter;
  logic [POS_W-1:0]       lead_pos;
  logic                   lead_found;
  logic signed [31:0]     int_part;
  logic [EXT_W-1:0]       norm_ext;
  logic [MANT_WIDTH-1:0]  norm_mant;
  logic [SQ_W-1:0]        sq;
  logic                   sq_ge2;
  logic [MANT_WIDTH:0]    mant_next;
  logic [FRAC_BITS-1:0]   frac_next;

  math_lead_one #(
    .WIDTH (DIN_WIDTH),
    .POS_W (POS_W)
  ) u_lead_one (
    .vec   (din_q),
    .pos   (lead_pos),
    .found (lead_found)
  );

  // Normalisation: integer part and the bits below the leading one,
  // left-aligned into the mantissa field (truncated or zero-filled).
  assign int_part  = $signed({{(32-POS_W){1'b0}}, lead_pos}) - DIN_FRAC;
  assign norm_ext  = {din_q, {MANT_WIDTH{1'b0}}} << (DIN_WIDTH - int'(lead_pos));
  assign norm_mant = norm_ext[EXT_W-1 -: MANT_WIDTH];

  // Square step: m*m lies in [1,4). At or above 2.0 the result bit is 1 and
  // the square is halved back into [1,2); either way keep 1.MANT_WIDTH.
  assign sq        = {{(MANT_WIDTH+1){1'b0}}, mant_q} * {{(MANT_WIDTH+1){1'b0}}, mant_q};
  assign sq_ge2    = sq[SQ_W-1];
  assign mant_next = sq_ge2 ? sq[SQ_W-1 -: MANT_WIDTH+1] : sq[SQ_W-2 -: MANT_WIDTH+1];
  assign frac_next = FRAC_BITS'({frac_q, sq_ge2});
  assign last_iter = (cnt_q == CNT_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d    = state_q;
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      IDLE: begin
        din_ready = 1'b1;
        accept    = din_valid;
        if (din_valid) state_d = NORM;
      end
      NORM: state_d = SQR;
      SQR:  if (last_iter) state_d = DONE;
      DONE: begin
        dout_valid = 1'b1;
        if (dout_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, normalisation, square-and-compare iterations
  // and the final result register, which holds until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q       <= '0;
      mant_q      <= '0;
      exp_q       <= '0;
      frac_q      <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      underflow_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            din_q       <= DIN;
            underflow_q <= 1'b0;
            zero_q      <= 1'b0;
          end
        end
        NORM: begin
          mant_q      <= {1'b1, norm_mant};
          exp_q       <= INT_BITS'(int_part);
          frac_q      <= '0;
          cnt_q       <= CNT_W'(FRAC_BITS);
          zero_q      <= !lead_found;
          underflow_q <= !lead_found || (int_part < 0);
        end
        SQR: begin
          mant_q <= mant_next;
          frac_q <= frac_next;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (last_iter) dout_q <= underflow_q ? '0 : {exp_q, frac_next};
        end
        default: ;
      endcase
    end
  end

  assign DOUT      = dout_q;
  assign underflow = underflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_math_log2_iter.sv
// Bench for math_log2_iter: directed operands with hand-derived log2
// results; a driver queues expectations, a monitor checks each handoff.
module tb_math_log2_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] DIN;
  logic        din_valid;
  logic        din_ready;
  logic [11:0] DOUT;
  logic        dout_valid;
  logic        dout_ready;
  logic        underflow;
  logic        zero;

  math_log2_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .DIN        (DIN),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .DOUT       (DOUT),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .underflow  (underflow),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] din;
    logic [11:0] dout;
    logic        uf;
    logic        z;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: latch the cycle dout_valid rises, compare on each handoff.
  logic prev_valid = 1'b0;
  int   rise_cyc   = 0;
  exp_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (dout_valid && !prev_valid) rise_cyc <= cyc;
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got DOUT 0x%0h with no pending operand", DOUT);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("dout[%06h]", e.din), 32'(DOUT), 32'(e.dout));
          check($sformatf("underflow[%06h]", e.din), 32'(underflow), 32'(e.uf));
          check($sformatf("zero[%06h]", e.din), 32'(zero), 32'(e.z));
          check($sformatf("latency[%06h]", e.din),
                32'((prev_valid ? rise_cyc : cyc) - e.acc_cyc), 32'd7);
        end
      end
      prev_valid <= dout_valid;
    end
  end

  // Present one operand, wait (bounded) for acceptance, queue expectation.
  task automatic send(input logic [23:0] din, input logic [11:0] dout,
                      input logic uf, input logic z);
    int n = 0;
    @(negedge clk);
    DIN       = din;
    din_valid = 1'b1;
    while (!din_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!din_ready) begin
      check("din_ready_timeout", 32'(din_ready), 32'd1);
      din_valid = 1'b0;
      return;
    end
    exp_q.push_back('{din, dout, uf, z, cyc + 1});
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    logic [23:0] din;
    logic [11:0] dout;
    logic        uf;
    logic        z;
  } vec_t;

  // Hand-derived: mantissa 1.5 yields fraction bits 100101 (37/64).
  vec_t vecs[13] = '{
    '{24'h000200, 12'h040, 1'b0, 1'b0},  // 2.0
    '{24'h000300, 12'h065, 1'b0, 1'b0},  // 3.0  -> 1 + 37/64
    '{24'h010000, 12'h200, 1'b0, 1'b0},  // 256.0
    '{24'hFFFFFF, 12'h3FF, 1'b0, 1'b0},  // largest input
    '{24'h000000, 12'h000, 1'b1, 1'b1},  // zero
    '{24'h000080, 12'h000, 1'b1, 1'b0},  // 0.5
    '{24'h000100, 12'h000, 1'b0, 1'b0},  // 1.0, smallest non-underflow
    '{24'h000180, 12'h025, 1'b0, 1'b0},  // 1.5
    '{24'h000600, 12'h0A5, 1'b0, 1'b0},  // 6.0  -> 2 + 37/64
    '{24'h800000, 12'h3C0, 1'b0, 1'b0},  // 32768.0
    '{24'h000001, 12'h000, 1'b1, 1'b0},  // smallest nonzero
    '{24'h0000FF, 12'h000, 1'b1, 1'b0},  // just below 1.0
    '{24'h000400, 12'h080, 1'b0, 1'b0}   // 4.0
  };

  initial begin
    int n;
    rst_n      = 1'b0;
    din_valid  = 1'b0;
    DIN        = '0;
    dout_ready = 1'b1;

    #3;
    check("rst_din_ready", 32'(din_ready), 32'd1);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_dout", 32'(DOUT), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) send(vecs[i].din, vecs[i].dout, vecs[i].uf, vecs[i].z);
    drain();

    // Backpressure: result held, new operand ignored while busy.
    dout_ready = 1'b0;
    send(24'h000200, 12'h040, 1'b0, 1'b0);
    n = 0;
    while (!dout_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", 32'(dout_valid), 32'd1);
    DIN       = 24'h000300;
    din_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("bp_dout_hold", 32'(DOUT), 32'h040);
      check("bp_valid_hold", 32'(dout_valid), 32'd1);
      check("bp_din_ready", 32'(din_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    check("handoff_valid_drop", 32'(dout_valid), 32'd0);
    check("handoff_din_ready", 32'(din_ready), 32'd1);
    repeat (15) @(negedge clk);
    check("ignored_operand", 32'(dout_valid), 32'd0);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of the square iterations.
    send(24'h000300, 12'h065, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_din_ready", 32'(din_ready), 32'd1);
    check("midrst_dout_valid", 32'(dout_valid), 32'd0);
    check("midrst_dout", 32'(DOUT), 32'd0);
    check("midrst_underflow", 32'(underflow), 32'd0);
    check("midrst_zero", 32'(zero), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(24'h000100, 12'h000, 1'b0, 1'b0);
    drain();

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
